// File: rtl/dot_host_pkg.sv
// Shared types and default sizes for the dot-product stream host.
package dot_host_pkg;

    // Host run state; also exported on the debug port of the top.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int DEF_IN_LEN  = 20;
    localparam int DEF_OUT_LEN = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 4410;

    typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/axis_word_buf.sv
// LEN x DATA_W register array: synchronous write, asynchronous read.
// Out-of-range writes are dropped and out-of-range reads return zero, so a
// caller may present a one-past-the-end index without side effects.
module axis_word_buf
    import dot_host_pkg::*;
#(
    parameter int LEN    = DEF_IN_LEN,
    parameter int DATA_W = DEF_DATA_W,
    parameter int AW     = $clog2(LEN)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [LEN];
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign w_wr_ok = ({1'b0, i_waddr} < (AW+1)'(LEN));
    assign w_rd_ok = ({1'b0, i_raddr} < (AW+1)'(LEN));

    // Storage is deliberately not reset: contents survive a host reset.
    always_ff @(posedge clk) begin
        if (i_we && w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_ok ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/axis_dot_host.sv
// Host for one dot-product stream core: streams the input buffer out as an
// AXI4-Stream master, collects results as a slave, checks TLAST framing,
// counts RUN cycles and aborts on timeout.
//
// Handshake rule on both streams: a word moves on a rising clk edge where
// TVALID and TREADY are both high; the master holds TDATA/TLAST/TVALID
// stable while TVALID=1 and TREADY=0. Both streams may move in one cycle.
module axis_dot_host
    import dot_host_pkg::*;
#(
    parameter int IN_LEN  = DEF_IN_LEN,
    parameter int OUT_LEN = DEF_OUT_LEN,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_we,
    input  logic [$clog2(IN_LEN)-1:0]  ld_addr,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       start,
    output logic [DATA_W-1:0]          M_AXIS_TDATA,
    output logic                       M_AXIS_TLAST,
    output logic                       M_AXIS_TVALID,
    input  logic                       M_AXIS_TREADY,
    input  logic [DATA_W-1:0]          S_AXIS_TDATA,
    input  logic                       S_AXIS_TLAST,
    input  logic                       S_AXIS_TVALID,
    output logic                       S_AXIS_TREADY,
    input  logic [$clog2(OUT_LEN)-1:0] rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err_last,
    output logic                       err_timeout,
    output logic [31:0]                cycles,
    output state_t                     dbg_state
);

    localparam int LDW = $clog2(IN_LEN);
    localparam int RDW = $clog2(OUT_LEN);
    localparam int TXW = $clog2(IN_LEN + 1);
    localparam int RXW = $clog2(OUT_LEN + 1);

    localparam logic [TXW-1:0] TX_END  = TXW'(IN_LEN);
    localparam logic [TXW-1:0] TX_LAST = TXW'(IN_LEN - 1);
    localparam logic [RXW-1:0] RX_END  = RXW'(OUT_LEN);
    localparam logic [RXW-1:0] RX_LAST = RXW'(OUT_LEN - 1);
    localparam logic [31:0]    TO_CYC  = 32'(TIMEOUT);

    state_t         r_state;
    state_t         w_next;
    logic [TXW-1:0] r_tx_idx;
    logic [RXW-1:0] r_rx_idx;
    logic [31:0]    r_cycles;
    logic           r_err_last;
    logic           r_err_timeout;

    logic           w_run;
    logic           w_tx_valid;
    logic           w_rx_ready;
    logic           w_tx_hs;
    logic           w_rx_hs;
    logic [TXW-1:0] w_tx_nxt;
    logic [RXW-1:0] w_rx_nxt;
    logic [31:0]    w_cycles_nxt;
    logic           w_complete;
    logic           w_timeout;
    logic           w_launch;

    assign w_run        = (r_state == RUN);
    assign w_tx_valid   = w_run && (r_tx_idx != TX_END);
    assign w_rx_ready   = w_run && (r_rx_idx != RX_END);
    assign w_tx_hs      = w_tx_valid && M_AXIS_TREADY;
    assign w_rx_hs      = w_rx_ready && S_AXIS_TVALID;
    assign w_tx_nxt     = r_tx_idx + TXW'(w_tx_hs);
    assign w_rx_nxt     = r_rx_idx + RXW'(w_rx_hs);
    assign w_cycles_nxt = r_cycles + 32'd1;
    // Completion looks at indices after this cycle's handshakes and wins
    // over a timeout landing on the same cycle.
    assign w_complete   = (w_tx_nxt == TX_END) && (w_rx_nxt == RX_END);
    assign w_timeout    = !w_complete && (w_cycles_nxt == TO_CYC);
    assign w_launch     = !w_run && start;

    axis_word_buf #(.LEN(IN_LEN), .DATA_W(DATA_W)) u_inbuf (
        .clk     (clk),
        .i_we    (ld_we),
        .i_waddr (ld_addr),
        .i_wdata (ld_data),
        .i_raddr (r_tx_idx[LDW-1:0]),
        .o_rdata (M_AXIS_TDATA)
    );

    axis_word_buf #(.LEN(OUT_LEN), .DATA_W(DATA_W)) u_outbuf (
        .clk     (clk),
        .i_we    (w_rx_hs),
        .i_waddr (r_rx_idx[RDW-1:0]),
        .i_wdata (S_AXIS_TDATA),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: start launches from any idle-like state and is ignored in RUN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (start) w_next = RUN;
            end
            RUN: begin
                if (w_complete)     w_next = DONE;
                else if (w_timeout) w_next = ERR;
            end
            default: w_next = IDLE;
        endcase
    end

    // Run datapath: indices, cycle counter and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_idx      <= '0;
            r_rx_idx      <= '0;
            r_cycles      <= '0;
            r_err_last    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else if (w_launch) begin
            r_tx_idx      <= '0;
            r_rx_idx      <= '0;
            r_cycles      <= '0;
            r_err_last    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else if (w_run) begin
            r_tx_idx <= w_tx_nxt;
            r_rx_idx <= w_rx_nxt;
            r_cycles <= w_cycles_nxt;
            if (w_rx_hs && (S_AXIS_TLAST != (r_rx_idx == RX_LAST))) begin
                r_err_last <= 1'b1;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign M_AXIS_TVALID = w_tx_valid;
    assign M_AXIS_TLAST  = w_tx_valid && (r_tx_idx == TX_LAST);
    assign S_AXIS_TREADY = w_rx_ready;
    assign busy          = w_run;
    assign done          = (r_state == DONE) || (r_state == ERR);
    assign err_last      = r_err_last;
    assign err_timeout   = r_err_timeout;
    assign cycles        = r_cycles;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_axis_dot_host.sv
// Directed bench for axis_dot_host with an in-bench echo core: the core
// returns input word 2j+1 as result j, starting 5 cycles after the last
// input word was accepted.
module tb_axis_dot_host;
  import dot_host_pkg::*;

  localparam int IN_LEN  = 20;
  localparam int OUT_LEN = 10;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4410;
  localparam logic [31:0] NEW_W15 = 32'h4248_0000;  // 50.0

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                       ld_we;
  logic [$clog2(IN_LEN)-1:0]  ld_addr;
  logic [DATA_W-1:0]          ld_data;
  logic                       start;
  logic [DATA_W-1:0]          m_tdata;
  logic                       m_tlast;
  logic                       m_tvalid;
  logic                       m_tready;
  logic [DATA_W-1:0]          s_tdata;
  logic                       s_tlast;
  logic                       s_tvalid;
  logic                       s_tready;
  logic [$clog2(OUT_LEN)-1:0] rd_addr;
  logic [DATA_W-1:0]          rd_data;
  logic                       busy;
  logic                       done;
  logic                       err_last;
  logic                       err_timeout;
  logic [31:0]                cycles;
  state_t                     dbg_state;

  axis_dot_host #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .start(start),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TLAST(m_tlast), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TLAST(s_tlast), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .err_last(err_last), .err_timeout(err_timeout), .cycles(cycles), .dbg_state(dbg_state)
  );

  // ---------------- reference data ----------------
  // Input word i holds the float (i+1).0; result j is input 2j+1 = (2j+2).0.
  logic [31:0] in_tab [IN_LEN] = '{
    32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
    32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000, 32'h4120_0000,
    32'h4130_0000, 32'h4140_0000, 32'h4150_0000, 32'h4160_0000, 32'h4170_0000,
    32'h4180_0000, 32'h4188_0000, 32'h4190_0000, 32'h4198_0000, 32'h41A0_0000};
  logic [31:0] exp_rd [OUT_LEN] = '{
    32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000, 32'h4120_0000,
    32'h4140_0000, 32'h4160_0000, 32'h4180_0000, 32'h4190_0000, 32'h41A0_0000};

  word_t       in_vals [IN_LEN];
  logic [DATA_W-1:0] exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          run_cyc;
  int          tx_cnt;
  int          rx_cnt;

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called on a negedge; leaves the bench on the negedge after the start edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_results(input string tag);
    for (int j = 0; j < OUT_LEN; j++) begin
      rd_addr = 4'(j);
      #1;
      check(tag, rd_data, exp_rd[j]);
    end
  endtask

  // One run, stepped cycle by cycle on negedges.
  // rdy_mode: 0 always ready, 1 random, 2 never. burst: core TVALID gaps.
  // last_at: result index the core flags with TLAST. respond: core answers.
  // abort_tx: stop stepping once this many words were sent (-1 = never).
  // start_cyc / ld_cyc: RUN cycle for a stray start / an input rewrite.
  task automatic do_run(input int rdy_mode, input bit burst, input int last_at,
                        input bit respond, input int abort_tx, input int start_cyc,
                        input int ld_cyc, input int budget);
    int    last_in_cyc;
    bit    prev_stall;
    word_t prev_data;
    logic  prev_last;
    word_t got[$];
    last_in_cyc = -1;
    prev_stall  = 1'b0;
    prev_data   = '0;
    prev_last   = 1'b0;
    run_cyc = 0;
    tx_cnt  = 0;
    rx_cnt  = 0;
    exp_q.delete();
    for (int i = 0; i < IN_LEN; i++) exp_q.push_back(in_vals[i]);
    while (busy === 1'b1 && run_cyc < budget) begin
      run_cyc++;
      start = (run_cyc == start_cyc);
      if (run_cyc == ld_cyc) begin
        ld_we   = 1'b1;
        ld_addr = 5'd15;
        ld_data = NEW_W15;
        exp_q[15 - tx_cnt] = NEW_W15;
        in_vals[15] = NEW_W15;
      end else begin
        ld_we = 1'b0;
      end
      if (prev_stall) begin
        check("tvalid_hold", 32'(m_tvalid), 32'd1);
        check("tdata_hold", m_tdata, prev_data);
        check("tlast_hold", 32'(m_tlast), 32'(prev_last));
      end
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("tx_extra", 32'(tx_cnt), 32'(IN_LEN - 1));
        end else begin
          check("tx_word", m_tdata, exp_q.pop_front());
        end
        check("tx_last", 32'(m_tlast), (tx_cnt == IN_LEN - 1) ? 32'd1 : 32'd0);
        got.push_back(m_tdata);
        tx_cnt++;
        if (tx_cnt == IN_LEN) last_in_cyc = run_cyc;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      s_tvalid = respond && (last_in_cyc >= 0) && (run_cyc >= last_in_cyc + 5) &&
                 (rx_cnt < OUT_LEN) && (!burst || ($urandom_range(0, 2) != 0));
      s_tdata  = s_tvalid ? got[2*rx_cnt+1] : '0;
      s_tlast  = s_tvalid && (rx_cnt == last_at);
      if (s_tvalid && s_tready) rx_cnt++;
      @(posedge clk);
      @(negedge clk);
      if (abort_tx >= 0 && tx_cnt == abort_tx) break;
    end
    start    = 1'b0;
    ld_we    = 1'b0;
    m_tready = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
    m_tready = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0; rd_addr = '0;
    for (int i = 0; i < IN_LEN; i++) in_vals[i] = in_tab[i];
    @(negedge clk);
    @(negedge clk);

    // Reset state.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tready", 32'(s_tready), 32'd0);
    check("rst_err_last", 32'(err_last), 32'd0);
    check("rst_err_to", 32'(err_timeout), 32'd0);
    check("rst_cycles", cycles, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < IN_LEN; i++) begin
      ld_we = 1'b1; ld_addr = 5'(i); ld_data = in_tab[i];
      @(negedge clk);
    end
    ld_we = 1'b0;

    // 1: nominal run, sink always ready, 5-cycle core latency.
    pulse_start();
    do_run(0, 1'b0, 9, 1'b1, -1, 0, 0, 500);
    check("s1_tx_count", 32'(tx_cnt), 32'd20);
    check("s1_done", 32'(done), 32'd1);
    check("s1_state", 32'(dbg_state), 32'(DONE));
    check("s1_err_last", 32'(err_last), 32'd0);
    check("s1_err_to", 32'(err_timeout), 32'd0);
    check("s1_cycles", cycles, 32'd34);
    check_results("s1_rd");

    // 2: random backpressure and bursty core.
    pulse_start();
    do_run(1, 1'b1, 9, 1'b1, -1, 0, 0, 1000);
    check("s2_busy", 32'(busy), 32'd0);
    check("s2_tx_count", 32'(tx_cnt), 32'd20);
    check("s2_rx_count", 32'(rx_cnt), 32'd10);
    check("s2_cycles", cycles, 32'(run_cyc));
    check("s2_err_last", 32'(err_last), 32'd0);
    check_results("s2_rd");

    // 3: core flags TLAST on result 4.
    pulse_start();
    do_run(0, 1'b0, 4, 1'b1, -1, 0, 0, 500);
    check("s3_state", 32'(dbg_state), 32'(DONE));
    check("s3_err_last", 32'(err_last), 32'd1);
    check("s3_err_to", 32'(err_timeout), 32'd0);
    check("s3_rx_count", 32'(rx_cnt), 32'd10);
    check_results("s3_rd");

    // 4: restart from DONE clears flags; stray start and an input rewrite mid-run.
    pulse_start();
    check("s4_busy", 32'(busy), 32'd1);
    check("s4_clr_err_last", 32'(err_last), 32'd0);
    check("s4_clr_cycles", cycles, 32'd0);
    check("s4_clr_done", 32'(done), 32'd0);
    do_run(0, 1'b0, 9, 1'b1, -1, 10, 3, 500);
    exp_rd[7] = NEW_W15;
    check("s4_cycles", cycles, 32'd34);
    check("s4_state", 32'(dbg_state), 32'(DONE));
    check("s4_err_last", 32'(err_last), 32'd0);
    check_results("s4_rd");

    // 5: reset mid-send at tx_idx=7, then a full restart.
    pulse_start();
    do_run(0, 1'b0, 9, 1'b1, 7, 0, 0, 500);
    check("s5_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("s5_rst_busy", 32'(busy), 32'd0);
    check("s5_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("s5_rst_tlast", 32'(m_tlast), 32'd0);
    check("s5_rst_tready", 32'(s_tready), 32'd0);
    check("s5_rst_cycles", cycles, 32'd0);
    check("s5_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    do_run(0, 1'b0, 9, 1'b1, -1, 0, 0, 500);
    check("s5_cycles", cycles, 32'd34);
    check("s5_tx_count", 32'(tx_cnt), 32'd20);
    check_results("s5_rd");

    // 6: core never responds and sink never ready -> timeout.
    pulse_start();
    do_run(2, 1'b0, 9, 1'b0, -1, 0, 0, 5000);
    check("s6_run_cyc", 32'(run_cyc), 32'(TIMEOUT));
    check("s6_cycles", cycles, 32'(TIMEOUT));
    check("s6_state", 32'(dbg_state), 32'(ERR));
    check("s6_err_to", 32'(err_timeout), 32'd1);
    check("s6_err_last", 32'(err_last), 32'd0);
    check("s6_done", 32'(done), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("s6_tvalid", 32'(m_tvalid), 32'd0);
      check("s6_tready", 32'(s_tready), 32'd0);
      @(negedge clk);
    end
    check("s6_cycles_frozen", cycles, 32'(TIMEOUT));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_dot_host.md
Name: axis_dot_host

Overview:
- Hardware host for the dot-product stream cores (e.g. axis_dot_20_10); replaces the bench-side driver/collector with synthesizable logic.
- Streams a locally stored input vector as AXI4-Stream master and collects the result vector as AXI4-Stream slave.
- Checks TLAST framing, counts cycles, flags timeouts, and exposes results through a register-style read port.
- Sits between the PS/register interface and one dot core.

Parameters:
- IN_LEN, 20, number of input words sent per run.
- OUT_LEN, 10, number of result words expected per run.
- DATA_W, 32, stream word width (IEEE-754 single bit patterns, passed through untouched).
- TIMEOUT, 4410, maximum RUN cycles before abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ld_we  in  1  write strobe into the input buffer
- ld_addr  in  $clog2(IN_LEN)  input buffer write index
- ld_data  in  DATA_W  input buffer write data
- start  in  1  single-cycle run request
- M_AXIS_TDATA  out  DATA_W  to core INPUT_AXIS_TDATA
- M_AXIS_TLAST  out  1
- M_AXIS_TVALID  out  1
- M_AXIS_TREADY  in  1
- S_AXIS_TDATA  in  DATA_W  from core OUTPUT_AXIS_TDATA
- S_AXIS_TLAST  in  1
- S_AXIS_TVALID  in  1
- S_AXIS_TREADY  out  1
- rd_addr  in  $clog2(OUT_LEN)  result buffer read index
- rd_data  out  DATA_W  combinational read of the result buffer
- busy  out  1  high in RUN
- done  out  1  high in DONE or ERR
- err_last  out  1  sticky framing error
- err_timeout  out  1  sticky timeout
- cycles  out  32  RUN cycle count of the last run

Behaviour:
- Reset (async, rst=1): state IDLE; tx_idx=0, rx_idx=0, cycles=0; M_AXIS_TVALID=0, M_AXIS_TLAST=0, S_AXIS_TREADY=0, busy=0, done=0, both err flags 0. Buffers are not cleared.
- FSM states: IDLE, RUN, DONE, ERR.
  - IDLE/DONE/ERR -> RUN on start=1; clears indices, cycles and err flags.
  - start is ignored while in RUN.
- ld_we writes the input buffer in any state. A write during RUN to an index not yet sent is transmitted with the new value.
- RUN, send side:
  - M_AXIS_TVALID=1 while tx_idx<IN_LEN; TDATA=inbuf[tx_idx]; TLAST=(tx_idx==IN_LEN-1).
  - tx_idx increments on TVALID&TREADY.
  - TVALID/TDATA/TLAST are held stable while TREADY=0.
  - After the last handshake TVALID drops the next cycle.
- RUN, receive side:
  - S_AXIS_TREADY=1 while rx_idx<OUT_LEN; runs concurrently with the send side, so early results are accepted.
  - On handshake: outbuf[rx_idx]<=TDATA and rx_idx increments.
  - If S_AXIS_TLAST != (rx_idx==OUT_LEN-1), set err_last. The word is still stored; a run is never ended early by TLAST.
- RUN -> DONE in the cycle after both tx_idx==IN_LEN and rx_idx==OUT_LEN, where each is updated by that cycle's handshakes.
- cycles increments every RUN cycle, including the final handshake cycle, and freezes on leaving RUN.
- RUN -> ERR when cycles reaches TIMEOUT without completion.
  - err_timeout=1; TVALID and TREADY drop immediately on entering ERR.
  - Partial results remain readable.
- Simultaneous send and receive handshakes in one cycle are both honoured.
- Reset mid-run aborts asynchronously to IDLE with all outputs at their reset values.

Decomposition:
- Package dot_host_pkg holds:
  - state_t enum {IDLE, RUN, DONE, ERR};
  - constants for the default IN_LEN/OUT_LEN/TIMEOUT;
  - a word_t typedef for DATA_W-bit words.
- One sub-module, axis_word_buf: a parameterised LEN×DATA_W register array with a synchronous write port and an asynchronous read port. It is instantiated twice, once as inbuf and once as outbuf.

Test Plan:
- Load 20 words 0x3F800000..(i·1.0 patterns); start; sink always ready; echo-model core with 5-cycle latency returns 10 words, TLAST on word 9 -> 20 sends with TLAST only on word 19; rd_data[0..9] match model; done=1; err flags=0; cycles equals the model-predicted count.
- Random backpressure: M_AXIS_TREADY toggling 50% and the core's TVALID bursty -> TDATA is stable while stalled and no word is dropped or duplicated; results identical to the first scenario.
- Core asserts TLAST on result word 4 -> err_last=1, all 10 words still captured, DONE reached.
- Core never responds -> ERR at cycles=4410, err_timeout=1, TVALID=TREADY=0 from that cycle on.
- rst asserted mid-send at tx_idx=7 -> outputs go to reset values immediately; a restart sends from word 0.
- start pulsed during RUN -> ignored, counters unaffected; start from DONE -> new run with err flags and cycles cleared.
